// File: rtl/fft_frame_counter_pkg.sv
// Shared definitions for the FFT frame/beat counter: FSM state encoding
// and the mode constants sampled at start.
package fft_cnt_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

endpackage

// File: rtl/fft_frame_counter_if.sv
// Control/status bundle of the FFT frame counter. The master side (address
// generator, stage controller) drives the requests and watches the count.
interface fft_frame_counter_if #(
  parameter int CNT_WIDTH   = 8,
  parameter int FRAME_WIDTH = 4
);

  logic [CNT_WIDTH-1:0]   thresh;
  logic                   mode;
  logic                   start;
  logic                   abort;
  logic                   valid;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   busy;
  logic                   not_zero;
  logic                   full;
  logic [FRAME_WIDTH-1:0] frame_cnt;
  logic [CNT_WIDTH-1:0]   cnt_rev;

  modport master (
    output thresh, mode, start, abort, valid,
    input  cnt, busy, not_zero, full, frame_cnt, cnt_rev
  );

  modport slave (
    input  thresh, mode, start, abort, valid,
    output cnt, busy, not_zero, full, frame_cnt, cnt_rev
  );

endinterface

// File: rtl/fft_frame_counter_bit_reverse.sv
// Combinational bit reversal: out[i] = in[WIDTH-1-i]. Produces the
// bit-reversed sample address used by the FFT input buffer.
module bit_reverse #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // Mirror the bit order of the input word.
  always_comb begin
    out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out[i] = in[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/fft_frame_counter.sv
// Frame/beat counter for the 256-point FFT datapath. Counts accepted valid
// beats up to a threshold latched at start, pulses full after the last beat
// of each frame and counts completed frames. One-shot or continuous mode,
// with a synchronous abort that overrides everything.
// Optional feature: define FFT_CNT_BITREV_EN to drive cnt_rev with the
// bit-reversed count; otherwise cnt_rev is tied to zero.
module fft_frame_counter
  import fft_cnt_pkg::*;
#(
  parameter int CNT_WIDTH   = 8,
  parameter int FRAME_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_frame_counter_if.slave bus
);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   thresh_q, thresh_d;
  logic                   mode_q, mode_d;
  logic                   full_q, full_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic                   not_zero_q;
  logic [CNT_WIDTH-1:0]   cnt_rev_q;

  // Next-state and datapath decode; abort wins over start and valid, and a
  // last beat coinciding with abort is dropped rather than counted.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    thresh_d = thresh_q;
    mode_d   = mode_q;
    full_d   = 1'b0;
    frame_d  = frame_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            thresh_d = bus.thresh;
            mode_d   = bus.mode;
            cnt_d    = '0;
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.valid) begin
            if (cnt_q == thresh_q) begin
              cnt_d   = '0;
              full_d  = 1'b1;
              frame_d = frame_q + 1'b1;
              if (mode_q == MODE_ONESHOT) begin
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and count registers; not_zero is derived from the next count so
  // it stays aligned with cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      thresh_q   <= '0;
      mode_q     <= MODE_ONESHOT;
      full_q     <= 1'b0;
      frame_q    <= '0;
      not_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      thresh_q   <= thresh_d;
      mode_q     <= mode_d;
      full_q     <= full_d;
      frame_q    <= frame_d;
      not_zero_q <= (cnt_d != '0);
    end
  end

`ifdef FFT_CNT_BITREV_EN
  logic [CNT_WIDTH-1:0] cnt_rev_d;

  bit_reverse #(.WIDTH(CNT_WIDTH)) u_bit_reverse (
    .in  (cnt_d),
    .out (cnt_rev_d)
  );

  // Bit-reversed address registered on the same edge as cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_rev_q <= '0;
    end else begin
      cnt_rev_q <= cnt_rev_d;
    end
  end
`else
  assign cnt_rev_q = '0;
`endif

  assign bus.cnt       = cnt_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.not_zero  = not_zero_q;
  assign bus.full      = full_q;
  assign bus.frame_cnt = frame_q;
  assign bus.cnt_rev   = cnt_rev_q;

endmodule

// File: doc/fft_frame_counter.md
# fft_frame_counter

Parametrised frame/beat counter for the 256-point FFT datapath. It counts accepted `valid` beats against a threshold latched at `start`. It flags the last beat of each frame and tracks completed frames. It supports one-shot and continuous (back-to-back frame) modes and a synchronous abort. Address generators and the butterfly stage controller use it to sequence sample loading and stage boundaries.

## Interface
Parameters:
- `CNT_WIDTH`, default 8: width of the beat counter and threshold. 8 covers 256 points.
- `FRAME_WIDTH`, default 4: width of the completed-frame counter.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `thresh`  in  CNT_WIDTH  index of the last beat in a frame. A frame is `thresh+1` beats. Sampled only when `start` is accepted.
- `mode`  in  1  0 = one-shot (single frame), 1 = continuous. Sampled only when `start` is accepted.
- `start`  in  1  request to begin counting. Accepted only in IDLE.
- `abort`  in  1  synchronous stop. Has priority over all other inputs.
- `valid`  in  1  beat strobe. Counted only in RUN.
- `cnt`  out  CNT_WIDTH  current beat index within the frame.
- `busy`  out  1  high in RUN.
- `not_zero`  out  1  high when `cnt != 0`.
- `full`  out  1  one-cycle pulse after the last beat of a frame is counted.
- `frame_cnt`  out  FRAME_WIDTH  number of completed frames. Wraps modulo 2^FRAME_WIDTH.
- `cnt_rev`  out  CNT_WIDTH  bit-reversed `cnt`. See Configuration.

## Operation
- **States:** IDLE and RUN.
- **IDLE:**
  - When `start` is high, latch `thresh` into `thresh_q` and `mode` into `mode_q`.
  - Clear `cnt` and go to RUN.
  - `valid` in the same cycle as `start` is not counted.
- **RUN, valid beat:**
  - `valid` with `cnt != thresh_q`: `cnt <= cnt+1`.
  - `valid` with `cnt == thresh_q` (last beat):
    - `cnt <= 0`.
    - `full <= 1` for one cycle.
    - `frame_cnt <= frame_cnt+1`.
    - If `mode_q==0`, go to IDLE. If `mode_q==1`, stay in RUN and count the next frame with the same `thresh_q`.
- **RUN, no valid beat:**
  - Without `valid`, `cnt` holds. There is no timeout.
  - `start` in RUN is ignored. `thresh` and `mode` changes in RUN have no effect.
- **Abort:** `abort` in any state:
  - next state IDLE, `cnt <= 0`, `full <= 0`.
  - `frame_cnt` is unchanged.
  - This holds even if a last beat is present in the same cycle: that frame is not counted.
- **Corner cases:**
  - `thresh == 0`: every `valid` in RUN is a last beat, so `full` pulses once per beat.
  - `thresh == 2^CNT_WIDTH-1`: `cnt` reaches the all-ones value, then returns to 0 without overflow.
  - Threshold equality is checked only on `valid` beats. A stale `cnt` value never fires `full`.
- **Register outputs:** `cnt`, `not_zero`, `full`, `frame_cnt` and `cnt_rev` are registered. `not_zero` is updated together with `cnt`, from its next value.
- **Reset values:**
  - state IDLE
  - `cnt=0`, `thresh_q=0`, `mode_q=0`
  - `busy=0`, `not_zero=0`, `full=0`, `frame_cnt=0`, `cnt_rev=0`

## Timing
- **Start latency:** `start` accepted at edge N; `busy` high after edge N. The first countable `valid` is sampled at edge N+1.
- **Count latency:** a `valid` sampled at edge k is visible on `cnt` after edge k.
- **Full timing:** `full` is high for exactly the cycle after the edge that consumed the last beat.
  - One-shot: `busy` falls at the same edge.
  - Continuous: `busy` stays high and `cnt` is 0, so a beat in the `full` cycle counts as beat 0 of the next frame.
- **Restart:** a new `start` is accepted in the `full` cycle of a one-shot frame, because the block is already in IDLE.
- **Abort timing:** takes effect at the next edge. Reset deasserted mid-frame leaves the block in IDLE, and the frame is lost.

## Configuration
- **`FFT_CNT_BITREV_EN` defined:**
  - `cnt_rev` holds the bit-reversed next value of `cnt`, over CNT_WIDTH bits. It is registered with `cnt`, so both update on the same edge.
  - It is used as the bit-reversed sample address for the FFT input buffer.
- **Not defined:** `cnt_rev` is tied to 0 and the reversal logic is absent. The port list is identical in both builds.

## Structure
- **Shared package `fft_cnt_pkg`:**
  - state enum `{ST_IDLE, ST_RUN}`
  - mode constants `MODE_ONESHOT=1'b0`, `MODE_CONT=1'b1`
- **Sub-module `bit_reverse`:**
  - Combinational, parameter WIDTH.
  - Instantiated only under `FFT_CNT_BITREV_EN`.

## Test plan
- **Basic one-shot:** `thresh=3`, `mode=0`, `start`, then 4 consecutive `valid` → `cnt` 1,2,3,0; `full` pulses one cycle after the 4th beat; `busy` falls; `frame_cnt=1`.
- **Continuous with gaps:** `thresh=255`, `mode=1`, 600 `valid` with random gaps → `full` pulses exactly twice, after beats 256 and 512; `cnt=88`; `busy` stays 1; `frame_cnt=2`.
- **Abort on last beat:** `thresh=7`, `mode=0`, 7 beats, then `abort` and `valid` together → `cnt=0`, no `full`, `frame_cnt` unchanged, IDLE.
- **Zero threshold and ignored inputs:** `thresh=0`, `mode=1` → `full` on every `valid`. `start` and a `thresh` change issued in RUN → no effect.
- **Restart and start/valid overlap:** `start` in the `full` cycle of a one-shot frame → new frame begins; `start`+`valid` in the same IDLE cycle → that `valid` not counted.
- **Bit reversal (`FFT_CNT_BITREV_EN`, CNT_WIDTH=8):** `cnt=1` → `cnt_rev=8'h80`; `cnt=8'h0C` → `cnt_rev=8'h30`. Without the macro, `cnt_rev` stays 0. Asserting reset mid-frame returns every output to its reset value.
